// File: rtl/uart_pkg.sv
// uart_pkg: shared frame constants, FSM encoding and checksum helper for the UART TX path
package uart_pkg;
  typedef enum logic [2:0] {IDLE, GRANT, SEND, WAIT_HI, WAIT_LO} state_t;
  localparam int FRAME_LEN = 5;
  localparam logic [7:0] DEF_HEADER = 8'hA5;
  localparam int TMO_W = 10;
  function automatic logic [7:0] chk_update(input logic [7:0] c, input logic [7:0] b);
    return c ^ b;
  endfunction
endpackage

// File: rtl/uart_tx_scheduler_if.sv
// uart_tx_scheduler_if: source request/ack bundle plus transmitter send/busy handshake
interface uart_tx_scheduler_if #(parameter int N_CH = 3);
  logic [N_CH-1:0]    req;
  logic [16*N_CH-1:0] req_data;
  logic [N_CH-1:0]    ack;
  logic               tx_send;
  logic [7:0]         tx_byte;
  logic               tx_busy;
  modport master(input req, req_data, tx_busy, output ack, tx_send, tx_byte);
  modport slave(output req, req_data, tx_busy, input ack, tx_send, tx_byte);
endinterface

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request after ptr
module rr_arbiter #(parameter int N_CH = 3) (
  input  logic [N_CH-1:0] req,
  input  logic [2:0]      ptr,
  output logic [N_CH-1:0] grant,
  output logic [2:0]      idx,
  output logic            valid
);
  logic [7:0] r8;
  assign r8 = 8'(req);
  always_comb begin
    idx = '0;
    valid = 1'b0;
    for (int i = 1; i <= N_CH; i++)
      if (!valid && r8[3'((int'(ptr) + i) % N_CH)]) begin
        valid = 1'b1;
        idx = 3'((int'(ptr) + i) % N_CH);
      end
  end
  assign grant = valid ? N_CH'(8'd1 << idx) : '0;
endmodule

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin packetizer feeding 5-byte frames to one UART transmitter
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int         N_CH    = 3,
  parameter logic [7:0] HEADER  = DEF_HEADER,
  parameter int         TIMEOUT = 1023
) (
  input  logic                clk_in,
  input  logic                reset,
  uart_tx_scheduler_if.master bus,
  output logic                busy,
  output logic                err
);
  localparam logic [2:0] LAST = 3'(FRAME_LEN - 1);
  state_t           state;
  logic [2:0]       ptr, ch, idx, gidx;
  logic [N_CH-1:0]  sel, gnt;
  logic             valid;
  logic [15:0]      word, wmux;
  logic [7:0]       chk, cur;
  logic [TMO_W-1:0] tcnt;
  rr_arbiter #(.N_CH(N_CH)) u_arb (
    .req(bus.req), .ptr(ptr), .grant(gnt), .idx(gidx), .valid(valid)
  );
  always_comb begin
    wmux = '0;
    for (int i = 0; i < N_CH; i++)
      if (sel[i]) wmux = bus.req_data[16*i +: 16];
  end
  assign cur = idx == 3'd0 ? HEADER :
               idx == 3'd1 ? {5'b0, ch} :
               idx == 3'd2 ? word[15:8] :
               idx == 3'd3 ? word[7:0] : chk;
  always_ff @(posedge clk_in or posedge reset)
    if (reset) begin
      state       <= IDLE;
      ptr         <= 3'(N_CH - 1);
      ch          <= '0;
      sel         <= '0;
      word        <= '0;
      idx         <= '0;
      chk         <= '0;
      tcnt        <= '0;
      bus.ack     <= '0;
      bus.tx_send <= 1'b0;
      bus.tx_byte <= '0;
      busy        <= 1'b0;
      err         <= 1'b0;
    end else begin
      bus.ack     <= '0;
      bus.tx_send <= 1'b0;
      case (state)
        IDLE: if (valid) begin
          ch    <= gidx;
          sel   <= gnt;
          state <= GRANT;
        end
        // A source that dropped its request before ack is skipped without a frame
        GRANT: if (|(bus.req & sel)) begin
          word    <= wmux;
          bus.ack <= sel;
          ptr     <= ch;
          idx     <= '0;
          chk     <= '0;
          busy    <= 1'b1;
          state   <= SEND;
        end else state <= IDLE;
        SEND: if (!bus.tx_busy) begin
          bus.tx_send <= 1'b1;
          bus.tx_byte <= cur;
          chk         <= chk_update(chk, cur);
          tcnt        <= '0;
          state       <= WAIT_HI;
        end
        WAIT_HI: if (bus.tx_busy) state <= WAIT_LO;
          else if (tcnt == TMO_W'(TIMEOUT)) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (tcnt != '1) tcnt <= tcnt + 1'b1;
        WAIT_LO: if (!bus.tx_busy) begin
          if (idx == LAST) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            idx   <= idx + 1'b1;
            state <= SEND;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: directed/randomized frames against a frame-level reference model
module tb_uart_tx_scheduler;
  localparam int N = 3;
  logic clk = 1'b0, rst = 1'b1;
  logic busy, err;
  bit tx_dead = 1'b0, tx_force = 1'b0;
  int k_hold = 2, cnt = 0;
  int n_cmp = 0, n_bad = 0, strobes = 0, bad_send = 0, ack_wide = 0;
  int m_ptr = N - 1;
  logic [7:0] bytes_q[$];
  logic [N-1:0] prev_ack = '0;
  logic [15:0] words [N];
  uart_tx_scheduler_if #(.N_CH(N)) bus();
  uart_tx_scheduler #(.N_CH(N), .HEADER(8'hA5), .TIMEOUT(1023)) dut (
    .clk_in(clk), .reset(rst), .bus(bus), .busy(busy), .err(err)
  );
  always #5 clk = ~clk;
  // Transmitter model: busy rises the cycle after an accepted send and stays up k_hold cycles
  always @(posedge clk or posedge rst)
    if (rst) cnt <= 0;
    else if (cnt > 0) cnt <= cnt - 1;
    else if (bus.tx_send && !tx_dead) cnt <= k_hold;
  assign bus.tx_busy = tx_force | (cnt > 0);
  always @(negedge clk) begin
    if (bus.tx_send) begin
      bytes_q.push_back(bus.tx_byte);
      strobes++;
      if (bus.tx_busy) bad_send++;
    end
    if (bus.ack != '0 && prev_ack != '0) ack_wide++;
    prev_ack = bus.ack;
  end
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic set_data();
    for (int i = 0; i < N; i++) bus.req_data[16*i +: 16] = words[i];
  endtask
  function automatic int next_ch(input int p, input logic [N-1:0] m);
    for (int i = 1; i <= N; i++) if (m[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction
  function automatic logic [39:0] frame(input int ch, input logic [15:0] w);
    logic [7:0] c;
    c = 8'(ch);
    return {8'hA5, c, w[15:8], w[7:0], 8'hA5 ^ c ^ w[15:8] ^ w[7:0]};
  endfunction
  task automatic cmp_bytes(input string tag, input logic [7:0] exp_q[$]);
    check({tag, "_len"}, 64'(bytes_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < bytes_q.size(); i++)
      check($sformatf("%s_b%0d", tag, i), bytes_q[i], exp_q[i]);
  endtask
  task automatic serve(input string tag, input logic [N-1:0] mask, input bit hold, input int n, input bit lat);
    logic [N-1:0] pend;
    logic [7:0] exp_q[$];
    logic [39:0] f;
    int got, first_ack, first_send, ch;
    pend = mask;
    got = 0;
    first_ack = -1;
    first_send = -1;
    bytes_q.delete();
    k_hold = $urandom_range(1, 4);
    set_data();
    bus.req = mask;
    for (int t = 0; t < 4000 && (got < n || busy); t++) begin
      @(negedge clk);
      if (bus.tx_send && first_send < 0) first_send = t;
      if (bus.ack != '0) begin
        if (first_ack < 0) first_ack = t;
        ch = next_ch(m_ptr, pend);
        if (ch < 0) check({tag, "_extra_ack"}, 64'(bus.ack), 64'd0);
        else begin
          m_ptr = ch;
          check({tag, "_ack"}, 64'(bus.ack), 64'(1 << ch));
          f = frame(ch, words[ch]);
          for (int i = 4; i >= 0; i--) exp_q.push_back(f[8*i +: 8]);
          words[ch] = 16'($urandom);
          set_data();
          got++;
          if (!hold) begin
            pend[ch] = 1'b0;
            bus.req[ch] = 1'b0;
          end else if (got == n) bus.req = '0;
        end
      end
    end
    check({tag, "_frames"}, 64'(got), 64'(n));
    if (lat) begin
      check({tag, "_ack_lat"}, 64'(first_ack), 64'd1);
      check({tag, "_send_lat"}, 64'(first_send), 64'd2);
    end
    check({tag, "_busy_end"}, 64'(busy), 64'd0);
    cmp_bytes(tag, exp_q);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_ptr = N - 1;
  endtask
  initial begin
    logic [7:0] exp_q[$];
    logic [39:0] f;
    int s0, ch;
    bit seen;
    bus.req = '0;
    for (int i = 0; i < N; i++) words[i] = '0;
    set_data();
    do_reset();
    check("rst_send", 64'(bus.tx_send), 64'd0);
    check("rst_byte", 64'(bus.tx_byte), 64'd0);
    check("rst_ack", 64'(bus.ack), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    // Single source with a known word and known checksum
    words[1] = 16'h1234;
    serve("single", 3'b010, 1'b0, 1, 1'b1);
    if (bytes_q.size() == 5) check("single_chk", 64'(bytes_q[4]), 64'h82);
    check("single_err", 64'(err), 64'd0);
    // All sources held high from a fresh pointer
    do_reset();
    words[0] = 16'h0001; words[1] = 16'h0002; words[2] = 16'h0003;
    serve("rr_all", 3'b111, 1'b1, 4, 1'b1);
    check("ack_pulse", 64'(ack_wide), 64'd0);
    for (int r = 0; r < 6; r++) begin
      logic [N-1:0] m;
      m = N'($urandom_range(1, 7));
      for (int i = 0; i < N; i++) words[i] = 16'($urandom);
      serve($sformatf("rnd%0d", r), m, 1'b0, $countones(m), 1'b0);
    end
    // Transmitter still busy when SEND is entered
    tx_force = 1'b1;
    s0 = strobes;
    words[2] = 16'($urandom);
    set_data();
    bus.req = 3'b100;
    repeat (10) @(negedge clk);
    check("hold_no_send", 64'(strobes - s0), 64'd0);
    check("hold_busy", 64'(busy), 64'd1);
    bus.req = '0;
    bytes_q.delete();
    tx_force = 1'b0;
    for (int t = 0; t < 200 && (bytes_q.size() < 5 || busy); t++) @(negedge clk);
    ch = next_ch(m_ptr, 3'b100);
    m_ptr = ch;
    f = frame(ch, words[2]);
    exp_q.delete();
    for (int i = 4; i >= 0; i--) exp_q.push_back(f[8*i +: 8]);
    check("hold_strobes", 64'(strobes - s0), 64'd5);
    cmp_bytes("hold", exp_q);
    // Transmitter never answers: timeout
    tx_dead = 1'b1;
    bytes_q.delete();
    words[0] = 16'($urandom);
    set_data();
    bus.req = 3'b001;
    repeat (3) @(negedge clk);
    bus.req = '0;
    m_ptr = next_ch(m_ptr, 3'b001);
    repeat (1000) @(negedge clk);
    check("tmo_err_early", 64'(err), 64'd0);
    check("tmo_busy_mid", 64'(busy), 64'd1);
    seen = 1'b0;
    for (int t = 0; t < 100 && !seen; t++) begin
      @(negedge clk);
      seen = err;
    end
    check("tmo_err", 64'(err), 64'd1);
    check("tmo_busy", 64'(busy), 64'd0);
    check("tmo_nbytes", 64'(bytes_q.size()), 64'd1);
    tx_dead = 1'b0;
    serve("after_tmo", 3'b110, 1'b0, 2, 1'b0);
    check("tmo_sticky", 64'(err), 64'd1);
    // Reset in the middle of byte 2, then re-arbitrate from the reset pointer
    bytes_q.delete();
    words[1] = 16'($urandom);
    set_data();
    bus.req = 3'b010;
    for (int t = 0; t < 100 && bytes_q.size() < 3; t++) @(negedge clk);
    check("mid_reached", 64'(bytes_q.size()), 64'd3);
    rst = 1'b1;
    #1;
    check("mid_rst_send", 64'(bus.tx_send), 64'd0);
    check("mid_rst_byte", 64'(bus.tx_byte), 64'd0);
    check("mid_rst_ack", 64'(bus.ack), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_err", 64'(err), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_ptr = N - 1;
    serve("post_rst", 3'b011, 1'b0, 2, 1'b0);
    check("no_send_while_busy", 64'(bad_send), 64'd0);
    check("ack_pulse_final", 64'(ack_wide), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
